// File: rtl/pressure_alarm_ctrl.sv
// Confirms sustained pressure warnings, latches the patient alarm until ack, and drives a square-wave buzzer.
// Outputs registered, one edge after the deciding input; no backpressure. PALARM_COUNT_EN adds the alarmCount output.
module pressure_alarm_ctrl #(
  parameter int CONFIRM_N = 4,
  parameter int CLEAR_N   = 8,
  parameter int BEEP_DIV  = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       sampleValid,
  input  logic       pWarning,
  input  logic       ack,
  output logic       alarm,
  output logic       buzzer,
  output logic [1:0] alarmState
`ifdef PALARM_COUNT_EN
  ,
  output logic [7:0] alarmCount
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2,
    ACKED   = 2'd3
  } state_t;

  localparam logic [3:0]  CONFIRM_LAST = 4'(CONFIRM_N);
  localparam logic [7:0]  CLEAR_LAST   = 8'(CLEAR_N);
  localparam logic [15:0] BEEP_LAST    = 16'(BEEP_DIV - 1);

  state_t      state, stateNxt;
  logic [3:0]  confirmCnt, confirmNxt;
  logic [7:0]  clearCnt, clearNxt;
  logic [15:0] beepCnt;
  logic        warnStrobe, normStrobe;

  assign warnStrobe = sampleValid & pWarning;
  assign normStrobe = sampleValid & ~pWarning;
  assign alarmState = state;

  always_comb begin
    stateNxt   = state;
    confirmNxt = confirmCnt;
    clearNxt   = clearCnt;
    case (state)
      IDLE: begin
        if (warnStrobe) begin
          if (CONFIRM_LAST == 4'd1) begin
            stateNxt   = ALARM;
            confirmNxt = 4'd0;
          end else begin
            stateNxt   = PENDING;
            confirmNxt = 4'd1;
          end
        end
      end
      PENDING: begin
        if (warnStrobe) begin
          if (confirmCnt + 4'd1 == CONFIRM_LAST) begin
            stateNxt   = ALARM;
            confirmNxt = 4'd0;
          end else begin
            confirmNxt = confirmCnt + 4'd1;
          end
        end else if (normStrobe) begin
          stateNxt   = IDLE;
          confirmNxt = 4'd0;
        end
      end
      // Samples are deliberately ignored here: the alarm stays latched until ack.
      ALARM: begin
        if (ack) begin
          stateNxt = ACKED;
          clearNxt = 8'd0;
        end
      end
      ACKED: begin
        if (normStrobe) begin
          if (clearCnt + 8'd1 == CLEAR_LAST) begin
            stateNxt = IDLE;
            clearNxt = 8'd0;
          end else begin
            clearNxt = clearCnt + 8'd1;
          end
        end else if (warnStrobe) begin
          clearNxt = 8'd0;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state      <= IDLE;
      confirmCnt <= 4'd0;
      clearCnt   <= 8'd0;
      beepCnt    <= 16'd0;
      alarm      <= 1'b0;
      buzzer     <= 1'b0;
    end else begin
      state      <= stateNxt;
      confirmCnt <= confirmNxt;
      clearCnt   <= clearNxt;
      alarm      <= (stateNxt == ALARM) || (stateNxt == ACKED);
      // Buzzer starts high on entry so the first audible half-period is full length.
      if (stateNxt == ALARM && state != ALARM) begin
        buzzer  <= 1'b1;
        beepCnt <= 16'd0;
      end else if (stateNxt == ALARM) begin
        if (beepCnt == BEEP_LAST) begin
          beepCnt <= 16'd0;
          buzzer  <= ~buzzer;
        end else begin
          beepCnt <= beepCnt + 16'd1;
        end
      end else begin
        buzzer  <= 1'b0;
        beepCnt <= 16'd0;
      end
    end
  end

`ifdef PALARM_COUNT_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      alarmCount <= 8'd0;
    end else if (stateNxt == ALARM && state != ALARM && alarmCount != 8'hFF) begin
      alarmCount <= alarmCount + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pressure_alarm_ctrl.sv
// Bench for pressure_alarm_ctrl at default parameters; alarmCount is checked only when PALARM_COUNT_EN is defined.
module tb_pressure_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       sampleValid = 1'b0;
  logic       pWarning = 1'b0;
  logic       ack = 1'b0;
  logic       alarm;
  logic       buzzer;
  logic [1:0] alarmState;
`ifdef PALARM_COUNT_EN
  logic [7:0] alarmCount;
`endif

  always #5 clk = ~clk;

  pressure_alarm_ctrl dut (
    .clk        (clk),
    .rstN       (rstN),
    .sampleValid(sampleValid),
    .pWarning   (pWarning),
    .ack        (ack),
    .alarm      (alarm),
    .buzzer     (buzzer),
    .alarmState (alarmState)
`ifdef PALARM_COUNT_EN
    ,
    .alarmCount (alarmCount)
`endif
  );

  typedef struct {
    string      nm;
    logic       a;
    logic       b;
    logic [1:0] st;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  bit   ok;
  int   errors = 0;
  int   checks = 0;

  // Monitor: every expectation pushed during a cycle is compared at the following falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      cur = q.pop_front();
      checks++;
      ok = (alarm === cur.a) && (buzzer === cur.b) && (alarmState === cur.st);
`ifdef PALARM_COUNT_EN
      ok = ok && (alarmCount === cur.cnt);
      if (!ok)
        $display("FAIL %s: got alarm=%b buzzer=%b state=%0d count=%0d, expected alarm=%b buzzer=%b state=%0d count=%0d",
                 cur.nm, alarm, buzzer, alarmState, alarmCount, cur.a, cur.b, cur.st, cur.cnt);
`else
      if (!ok)
        $display("FAIL %s: got alarm=%b buzzer=%b state=%0d, expected alarm=%b buzzer=%b state=%0d",
                 cur.nm, alarm, buzzer, alarmState, cur.a, cur.b, cur.st);
`endif
      if (!ok) errors++;
    end
  end

  task automatic want(input string nm, input int a, input int b, input int st, input int cnt);
    exp_t e;
    e.nm  = nm;
    e.a   = a[0];
    e.b   = b[0];
    e.st  = st[1:0];
    e.cnt = cnt[7:0];
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe(input bit w);
    sampleValid = 1'b1;
    pWarning    = w;
    tick();
    sampleValid = 1'b0;
    pWarning    = 1'b0;
  endtask

  task automatic raiseClear();
    repeat (4) strobe(1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    repeat (8) strobe(1'b0);
  endtask

  initial begin
    idle(2);
    want("reset", 0, 0, 0, 0);
    rstN = 1'b1;
    tick();

    // Four spaced warnings raise the alarm on the fourth strobe edge.
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1);
      idle(4);
    end
    want("pending after 3", 0, 0, 1, 0);
    strobe(1'b1);
    want("raise", 1, 1, 2, 1);

    // Buzzer: 16 cycles high, 16 low, then high again.
    idle(15);
    want("beep high end", 1, 1, 2, 1);
    idle(1);
    want("beep low start", 1, 0, 2, 1);
    idle(15);
    want("beep low end", 1, 0, 2, 1);
    idle(1);
    want("beep high again", 1, 1, 2, 1);
    strobe(1'b0);
    want("alarm latched", 1, 1, 2, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    want("ack", 1, 0, 3, 1);

    // In ACKED a warning restarts the normal run; held ack has no effect.
    ack = 1'b1;
    repeat (5) strobe(1'b0);
    ack = 1'b0;
    want("acked 5 normal", 1, 0, 3, 1);
    strobe(1'b1);
    want("acked warning", 1, 0, 3, 1);
    repeat (7) strobe(1'b0);
    want("acked 7 normal", 1, 0, 3, 1);
    strobe(1'b0);
    want("release", 0, 0, 0, 1);

    // Isolated warnings are filtered; ack is ignored while pending.
    ack = 1'b1;
    strobe(1'b1);
    strobe(1'b1);
    ack = 1'b0;
    strobe(1'b1);
    want("pending 3 again", 0, 0, 1, 1);
    strobe(1'b0);
    want("pending abort", 0, 0, 0, 1);
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b1);
    want("confirm restarted", 0, 0, 1, 1);
    strobe(1'b1);
    want("raise 2", 1, 1, 2, 2);

    // Simultaneous ack and normal sample: the sample must not count.
    sampleValid = 1'b1;
    pWarning    = 1'b0;
    ack         = 1'b1;
    tick();
    sampleValid = 1'b0;
    ack         = 1'b0;
    want("ack with sample", 1, 0, 3, 2);
    repeat (7) strobe(1'b0);
    want("needs 8 normal", 1, 0, 3, 2);
    strobe(1'b0);
    want("release 2", 0, 0, 0, 2);

    // Asynchronous reset in the middle of an alarm.
    repeat (4) strobe(1'b1);
    want("raise 3", 1, 1, 2, 3);
    idle(3);
    #1 rstN = 1'b0;
    #1;
    want("async reset", 0, 0, 0, 0);
    @(negedge clk);
    #1 rstN = 1'b1;
    tick();
    want("idle after reset", 0, 0, 0, 0);
    strobe(1'b1);
    want("recover pending", 0, 0, 1, 0);
    strobe(1'b0);
    want("recover idle", 0, 0, 0, 0);

`ifdef PALARM_COUNT_EN
    repeat (3) raiseClear();
    want("count 3", 0, 0, 0, 3);
    repeat (257) raiseClear();
    want("count saturates", 0, 0, 0, 255);
`endif

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pressure_alarm_ctrl.md
# pressure_alarm_ctrl

Downstream of the pressure analyzer: consumes its per-sample `pWarning` flag, confirms a sustained over/under-pressure condition, and drives the patient alarm and buzzer. Isolated warning samples are filtered out. A confirmed alarm latches until the nurse acknowledges it. After acknowledgement, the alarm self-clears only once pressure has been normal for a configured run of samples.

## Interface
Parameters:
- `CONFIRM_N`, 4: consecutive warning samples needed to raise the alarm (range 1..15).
- `CLEAR_N`, 8: consecutive normal samples, after ack, needed to release the alarm (range 1..255).
- `BEEP_DIV`, 16: clk cycles per buzzer half-period (range 2..65535).

Ports:
- `clk` in 1: system clock, rising edge.
- `rstN` in 1: reset, asynchronous, active-low.
- `sampleValid` in 1: one-cycle strobe; `pWarning` is meaningful only when this is high.
- `pWarning` in 1: warning flag from the pressure analyzer.
- `ack` in 1: nurse acknowledge, level or pulse, sampled each cycle.
- `alarm` out 1: alarm lamp, registered.
- `buzzer` out 1: audible square wave, registered.
- `alarmState` out 2: current FSM state encoding.
- `alarmCount` out 8: number of alarms raised (present only with `PALARM_COUNT_EN`).

## Operation
- FSM states: IDLE=0, PENDING=1, ALARM=2, ACKED=3. Counters used: `confirmCnt` 4b, `clearCnt` 8b, `beepCnt` 16b.
- IDLE:
  - On `sampleValid & pWarning`, go to PENDING with `confirmCnt`=1.
  - If `CONFIRM_N`=1, go directly to ALARM instead.
- PENDING:
  - `sampleValid & pWarning`: increment `confirmCnt`; reaching `CONFIRM_N` moves to ALARM.
  - `sampleValid & !pWarning`: return to IDLE, `confirmCnt`=0.
  - No strobe: hold state and counter.
- ALARM:
  - `alarm`=1 and the buzzer toggles.
  - `ack`=1 moves to ACKED with `clearCnt`=0.
  - Samples are ignored; the alarm stays latched even if pressure returns to normal.
- ACKED:
  - `alarm`=1, `buzzer`=0.
  - `sampleValid & !pWarning` increments `clearCnt`; reaching `CLEAR_N` returns to IDLE.
  - `sampleValid & pWarning` resets `clearCnt` to 0 and stays in ACKED (no re-beep).
  - `ack` is ignored.
- `ack` is ignored in IDLE and PENDING.
- Buzzer:
  - On entry to ALARM: `buzzer`←1, `beepCnt`←0.
  - Each ALARM cycle: `beepCnt` increments; at `BEEP_DIV`-1 it wraps to 0 and `buzzer` toggles.
  - `buzzer`=0 in all other states.
- Counter widths: counters never wrap in normal use, since each exits state at its threshold. `confirmCnt` and `clearCnt` are cleared on every state entry.

## Timing
- All state, counters and outputs update on the rising `clk` edge. Outputs are registered; there is no combinational path from input to output.
- Raise latency: the edge that samples the `CONFIRM_N`-th consecutive warning strobe also sets `alarm`=1 and `buzzer`=1. Both are visible in the following cycle.
- Ack latency: `ack` sampled at edge N gives `buzzer`=0 and `alarmState`=3 after edge N.
- Release: the edge sampling the `CLEAR_N`-th normal strobe sets `alarm`=0 and `alarmState`=0.
- Simultaneous `ack` and `sampleValid` in ALARM: ack wins; the sample does not count toward `clearCnt`.
- Back-to-back strobes on every cycle are legal and each is counted.
- Reset asserted at any time: immediately forces IDLE, all counters 0, `alarm`=0, `buzzer`=0, `alarmCount`=0. Recovery begins on the first edge after `rstN` deasserts.

## Configuration
- `PALARM_COUNT_EN` defined:
  - `alarmCount` port and an 8-bit counter exist.
  - The counter increments by 1 on every transition into ALARM (from IDLE or PENDING).
  - It saturates at 255 and clears only on reset.
- Not defined: no port, no counter logic; all other behaviour is identical.

## Test plan
- Defaults; 4 strobes with `pWarning`=1, one every 5 cycles → `alarm`=1 one cycle after the 4th strobe edge; `alarmState`=2.
- 3 warning strobes then 1 normal strobe → `alarmState` returns to 0, `alarm` never asserts; `alarmCount` unchanged.
- In ALARM with `BEEP_DIV`=16, no ack → `buzzer` reads 1 for 16 cycles, 0 for 16, repeating. Then `ack` pulse → `buzzer`=0 next cycle, `alarm` stays 1.
- In ACKED: 5 normal strobes, 1 warning strobe, 8 normal strobes → `alarm` drops only after the 8th normal strobe of the final run.
- `ack` and `sampleValid` (pWarning=0) in the same ALARM cycle → ACKED with `clearCnt`=0, so 8 further normal strobes are needed. `rstN` pulled low mid-ALARM → `alarm`=`buzzer`=0 asynchronously, `alarmState`=0.
- With `PALARM_COUNT_EN`, raise and clear 3 alarms → `alarmCount`=3. Force 260 alarms → `alarmCount` holds at 255.
